mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives ImmSel to the immediate generator, plus ALU operand/op selects, PC update, memory request handshakes and register-file write enable.
- Sits beside the datapath; reads the instruction register and the branch comparator result.

---
 rtl/rv_pkg.sv | 101 ++++++++++
 rtl/mc_ctrl_if.sv | 67 ++++++
 rtl/mc_decode.sv | 125 ++++++++++++
 rtl/mc_ctrl.sv | 81 ++++++++
 tb/tb_mc_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I control types for the multi-cycle core.
// Opcodes, control enums and the decoded control bundle.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I  = 3'b000,
    IMM_S  = 3'b001,
    IMM_B  = 3'b010,
    IMM_J  = 3'b011,
    IMM_U  = 3'b100,
    IMM_SH = 3'b101
  } imm_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_ILL,
    C_OP,
    C_OPIMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC
  } cls_e;

  typedef struct packed {
    logic     imem_req;
    logic     ir_we;
    logic     pc_we;
    logic     pc_sel;
    imm_sel_e imm_sel;
    logic     alu_a_sel;
    logic     alu_b_sel;
    alu_op_e  alu_op;
    logic     dmem_req;
    logic     dmem_we;
    logic     rf_we;
    wb_sel_e  wb_sel;
    logic     illegal;
  } ctrl_t;

  function automatic cls_e op_class(input logic [6:0] opc);
    cls_e c;
    c = C_ILL;
    unique case (opc)
      OPC_OP:     c = C_OP;
      OPC_OPIMM:  c = C_OPIMM;
      OPC_LOAD:   c = C_LOAD;
      OPC_STORE:  c = C_STORE;
      OPC_BRANCH: c = C_BRANCH;
      OPC_JAL:    c = C_JAL;
      OPC_JALR:   c = C_JALR;
      OPC_LUI:    c = C_LUI;
      OPC_AUIPC:  c = C_AUIPC;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath/memory signal bundle.
// master = controller side, slave = datapath side.
interface mc_ctrl_if #(
  parameter int Width = 32
);
  import rv_pkg::*;

  logic [Width-1:0] inst;
  logic             imem_ready;
  logic             dmem_ready;
  logic             br_taken;

  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  imm_sel_e         ImmSel;
  logic             alu_a_sel;
  logic             alu_b_sel;
  alu_op_e          alu_op;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_we;
  wb_sel_e          wb_sel;
  logic             illegal;

  modport master (
    input  inst,
    input  imem_ready,
    input  dmem_ready,
    input  br_taken,
    output imem_req,
    output ir_we,
    output pc_we,
    output pc_sel,
    output ImmSel,
    output alu_a_sel,
    output alu_b_sel,
    output alu_op,
    output dmem_req,
    output dmem_we,
    output rf_we,
    output wb_sel,
    output illegal
  );

  modport slave (
    output inst,
    output imem_ready,
    output dmem_ready,
    output br_taken,
    input  imem_req,
    input  ir_we,
    input  pc_we,
    input  pc_sel,
    input  ImmSel,
    input  alu_a_sel,
    input  alu_b_sel,
    input  alu_op,
    input  dmem_req,
    input  dmem_we,
    input  rf_we,
    input  wb_sel,
    input  illegal
  );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational control decode from (state, inst).
// Holds no state; the FSM register lives in mc_ctrl.
module mc_decode
  import rv_pkg::*;
#(
  parameter int Width = 32
) (
  input  state_e           state,
  input  logic [Width-1:0] inst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             br_taken,
  output cls_e             cls,
  output ctrl_t            ctrl
);

  logic [2:0] f3;
  logic       rd_nz;
  logic       alt;
  logic       is_st;
  imm_sel_e   imm;
  alu_op_e    op;
  logic       unused_bits;

  assign f3          = inst[14:12];
  assign rd_nz       = |inst[11:7];
  assign alt         = inst[30];
  assign cls         = op_class(inst[6:0]);
  assign is_st       = (cls == C_STORE);
  assign unused_bits = ^{inst[31], inst[29:15]};

  // immediate format follows the instruction class
  always_comb begin
    imm = IMM_I;
    unique case (1'b1)
      cls == C_OPIMM && (f3 == 3'b001 || f3 == 3'b101):
        imm = IMM_SH;
      cls == C_STORE:
        imm = IMM_S;
      cls == C_BRANCH:
        imm = IMM_B;
      cls == C_JAL:
        imm = IMM_J;
      cls == C_LUI || cls == C_AUIPC:
        imm = IMM_U;
      default: ;
    endcase
  end

  // ALU function from funct fields; shifts-imm only honour bit 30 on SRAI
  always_comb begin
    op = ALU_ADD;
    unique case (1'b1)
      cls == C_OP:
        op = alu_op_e'({alt, f3});
      cls == C_OPIMM:
        op = alu_op_e'({alt & (f3 == 3'b101), f3});
      default: ;
    endcase
  end

  // per-state control outputs; anything not set stays 0
  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        ctrl.ir_we    = imem_ready;
      end
      ST_DECODE: begin
        ctrl.imm_sel = imm;
      end
      ST_EXEC: begin
        ctrl.imm_sel = imm;
        ctrl.alu_op  = op;
        unique case (cls)
          C_OPIMM, C_LOAD, C_STORE: begin
            ctrl.alu_b_sel = 1'b1;
          end
          C_AUIPC: begin
            ctrl.alu_a_sel = 1'b1;
            ctrl.alu_b_sel = 1'b1;
          end
          C_BRANCH: begin
            ctrl.alu_a_sel = 1'b1;
            ctrl.alu_b_sel = 1'b1;
            ctrl.pc_we     = 1'b1;
            ctrl.pc_sel    = br_taken;
          end
          C_JAL, C_JALR: begin
            ctrl.alu_a_sel = (cls == C_JAL);
            ctrl.alu_b_sel = 1'b1;
            ctrl.pc_we     = 1'b1;
            ctrl.pc_sel    = 1'b1;
            ctrl.rf_we     = rd_nz;
            ctrl.wb_sel    = WB_PC4;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl.imm_sel   = imm;
        ctrl.alu_b_sel = 1'b1;
        ctrl.dmem_req  = 1'b1;
        ctrl.dmem_we   = is_st;
        ctrl.pc_we     = is_st & dmem_ready;
      end
      ST_WB: begin
        ctrl.imm_sel = imm;
        ctrl.rf_we   = rd_nz;
        ctrl.pc_we   = 1'b1;
        unique case (1'b1)
          cls == C_LOAD: ctrl.wb_sel = WB_MEM;
          cls == C_LUI:  ctrl.wb_sel = WB_IMM;
          default:       ctrl.wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control FSM.
// One instruction at a time: fetch, decode, exec, mem, wb.
module mc_ctrl
  import rv_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  state_e state;
  state_e state_nxt;
  cls_e   cls;
  ctrl_t  ctrl;

  mc_decode #(
    .Width(Width)
  ) u_dec (
    .state     (state),
    .inst      (bus.inst),
    .imem_ready(bus.imem_ready),
    .dmem_ready(bus.dmem_ready),
    .br_taken  (bus.br_taken),
    .cls       (cls),
    .ctrl      (ctrl)
  );

  // state register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // sequencing; TRAP only leaves through reset
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        state_nxt = (cls == C_ILL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        unique case (cls)
          C_OP, C_OPIMM, C_LUI, C_AUIPC:
            state_nxt = ST_WB;
          C_LOAD, C_STORE:
            state_nxt = ST_MEM;
          default:
            state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.dmem_ready)
          state_nxt = (cls == C_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign bus.imem_req  = ctrl.imem_req;
  assign bus.ir_we     = ctrl.ir_we;
  assign bus.pc_we     = ctrl.pc_we;
  assign bus.pc_sel    = ctrl.pc_sel;
  assign bus.ImmSel    = ctrl.imm_sel;
  assign bus.alu_a_sel = ctrl.alu_a_sel;
  assign bus.alu_b_sel = ctrl.alu_b_sel;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.dmem_req  = ctrl.dmem_req;
  assign bus.dmem_we   = ctrl.dmem_we;
  assign bus.rf_we     = ctrl.rf_we;
  assign bus.wb_sel    = ctrl.wb_sel;
  assign bus.illegal   = ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream vs per-instruction
// expected cycle sequences built from the control rules.
module tb_mc_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic [2:0] imm;
    logic       a;
    logic       b;
    logic [3:0] op;
    logic       dreq;
    logic       dwe;
    logic       rf;
    logic [1:0] wb;
    logic       ill;
  } ov_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        ir;
    logic        dr;
    logic        bt;
    ov_t         e;
  } cyc_t;

  localparam int K_ILL  = 0;
  localparam int K_OP   = 1;
  localparam int K_OPI  = 2;
  localparam int K_LD   = 3;
  localparam int K_ST   = 4;
  localparam int K_BR   = 5;
  localparam int K_JAL  = 6;
  localparam int K_JALR = 7;
  localparam int K_LUI  = 8;
  localparam int K_AUI  = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  cyc_t q[$];

  mc_ctrl_if #(.Width(32)) bus ();

  mc_ctrl #(.Width(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h exp %h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic int kind(input logic [6:0] o);
    case (o)
      7'h33:   return K_OP;
      7'h13:   return K_OPI;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h37:   return K_LUI;
      7'h17:   return K_AUI;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input int k,
                                        input logic [2:0] f3);
    case (k)
      K_OPI:        return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
      K_ST:         return 3'd1;
      K_BR:         return 3'd2;
      K_JAL:        return 3'd3;
      K_LUI, K_AUI: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic ov_t obs();
    ov_t o;
    o.imem_req = bus.imem_req;
    o.ir_we    = bus.ir_we;
    o.pc_we    = bus.pc_we;
    o.pc_sel   = bus.pc_sel;
    o.imm      = bus.ImmSel;
    o.a        = bus.alu_a_sel;
    o.b        = bus.alu_b_sel;
    o.op       = bus.alu_op;
    o.dreq     = bus.dmem_req;
    o.dwe      = bus.dmem_we;
    o.rf       = bus.rf_we;
    o.wb       = bus.wb_sel;
    o.ill      = bus.illegal;
    return o;
  endfunction

  function automatic void push(input logic [31:0] i,
                               input logic ir,
                               input logic dr,
                               input logic bt,
                               input ov_t e);
    cyc_t c;
    c.inst = i;
    c.ir   = ir;
    c.dr   = dr;
    c.bt   = bt;
    c.e    = e;
    q.push_back(c);
  endfunction

  // expected cycle-by-cycle outputs for one instruction
  function automatic void build(input logic [31:0] i,
                                input int iw,
                                input int dw,
                                input logic bt);
    int         k;
    logic [2:0] f3;
    logic       rdnz;
    logic [2:0] imm;
    ov_t        e;
    k    = kind(i[6:0]);
    f3   = i[14:12];
    rdnz = |i[11:7];
    imm  = imm_of(k, f3);
    q.delete();
    for (int n = 0; n < iw; n++) begin
      e = '0;
      e.imem_req = 1'b1;
      push($urandom, 1'b0, rbit(), rbit(), e);
    end
    e = '0;
    e.imem_req = 1'b1;
    e.ir_we    = 1'b1;
    push($urandom, 1'b1, rbit(), rbit(), e);
    e = '0;
    e.imm = imm;
    push(i, rbit(), rbit(), rbit(), e);
    if (k == K_ILL) begin
      for (int n = 0; n < 4; n++) begin
        e = '0;
        e.ill = 1'b1;
        push(i, rbit(), rbit(), rbit(), e);
      end
      return;
    end
    e = '0;
    e.imm = imm;
    case (k)
      K_OP: e.op = {i[30], f3};
      K_OPI: begin
        e.b  = 1'b1;
        e.op = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
      end
      K_LD, K_ST: e.b = 1'b1;
      K_BR: begin
        e.a      = 1'b1;
        e.b      = 1'b1;
        e.pc_we  = 1'b1;
        e.pc_sel = bt;
      end
      K_JAL, K_JALR: begin
        e.a      = (k == K_JAL);
        e.b      = 1'b1;
        e.pc_we  = 1'b1;
        e.pc_sel = 1'b1;
        e.rf     = rdnz;
        e.wb     = 2'd2;
      end
      K_AUI: begin
        e.a = 1'b1;
        e.b = 1'b1;
      end
      default: ;
    endcase
    push(i, rbit(), rbit(), bt, e);
    if (k == K_LD || k == K_ST) begin
      e = '0;
      e.imm  = imm;
      e.b    = 1'b1;
      e.dreq = 1'b1;
      e.dwe  = (k == K_ST);
      for (int n = 0; n < dw; n++)
        push(i, rbit(), 1'b0, rbit(), e);
      e.pc_we = (k == K_ST);
      push(i, rbit(), 1'b1, rbit(), e);
    end
    if (k == K_OP || k == K_OPI || k == K_LD ||
        k == K_LUI || k == K_AUI) begin
      e = '0;
      e.imm   = imm;
      e.rf    = rdnz;
      e.pc_we = 1'b1;
      e.wb    = (k == K_LD) ? 2'd1 : (k == K_LUI) ? 2'd3 : 2'd0;
      push(i, rbit(), rbit(), rbit(), e);
    end
  endfunction

  task automatic drive_rand();
    bus.inst       = $urandom;
    bus.imem_ready = rbit();
    bus.dmem_ready = rbit();
    bus.br_taken   = rbit();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_rand();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq("rst", 32'(obs()), 32'd0);
      @(posedge clk);
      #1;
      drive_rand();
    end
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check_eq("boot", 32'(obs()), 32'd0);
  endtask

  task automatic run(input int abort_at);
    int pcw;
    pcw = 0;
    for (int n = 0; n < q.size(); n++) begin
      if (n == abort_at) begin
        do_reset();
        return;
      end
      @(posedge clk);
      #1;
      bus.inst       = q[n].inst;
      bus.imem_ready = q[n].ir;
      bus.dmem_ready = q[n].dr;
      bus.br_taken   = q[n].bt;
      @(negedge clk);
      check_eq($sformatf("cyc%0d", n), 32'(obs()), 32'(q[n].e));
      pcw += int'(bus.pc_we);
    end
    if (q[q.size()-1].e.ill) begin
      check_eq("trap_ill", 32'(bus.illegal), 32'd1);
      do_reset();
    end else begin
      check_eq("pcw_once", pcw, 1);
    end
  endtask

  logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23,
                            7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [31:0] ri;
  logic [6:0]  ro;
  int          ab;

  initial begin
    bus.inst       = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    do_reset();
    build(32'h00500093, 0, 0, rbit());
    run(-1);
    build(32'h4030D113, 0, 0, rbit());
    run(-1);
    build(32'h0080A183, 0, 3, rbit());
    run(-1);
    build(32'h00208463, 0, 0, 1'b1);
    run(-1);
    build(32'h00208463, 1, 0, 1'b0);
    run(-1);
    build(32'h0000007F, 0, 0, 1'b0);
    run(-1);
    for (int t = 0; t < 400; t++) begin
      ri = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        ro = 7'(ri);
        while (kind(ro) != K_ILL) ro = 7'($urandom);
      end else begin
        ro = opcs[$urandom_range(0, 8)];
      end
      ri[6:0] = ro;
      if ($urandom_range(0, 5) == 0) ri[11:7] = 5'd0;
      build(ri, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
      ab = -1;
      if ($urandom_range(0, 9) == 0)
        ab = int'($urandom_range(1, q.size() - 1));
      run(ab);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
